// File: rtl/spi_master_fl_param.sv
// SPI NOR-flash master (mode 0, MSB first): command, address, dummy and data phases per request.
// Optional macro SPI_FL_WIP_POLL_EN: after a write, poll status (0x05) until WIP clears.
module spi_master_fl_param #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned DUMMY_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ss,
  output logic                       sclk,
  output logic                       mosi,
  input  logic                       miso,
  input  logic [7:0]                 command,
  input  logic [ADDR_W-1:0]          address,
  input  logic [1:0]                 cmd_type,
  input  logic [$clog2(MAX_BYTES):0] nbytes,
  input  logic [DUMMY_W-1:0]         ndummy,
  input  logic [8*MAX_BYTES-1:0]     data_in,
  output logic [8*MAX_BYTES-1:0]     data_out,
  input  logic                       validflag,
  output logic                       tready,
  output logic                       validflag_out
);

  localparam int unsigned NB_W   = $clog2(MAX_BYTES) + 1;
  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned TX_W   = 8 + ADDR_W + DATA_W;
  localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned MAX_DM = (((1 << DUMMY_W) - 1) > MAX_AD) ? ((1 << DUMMY_W) - 1) : MAX_AD;
  localparam int unsigned CNT_W  = $clog2(MAX_DM + 1);

  localparam logic [1:0] TYPE_CMD = 2'b00;
  localparam logic [1:0] TYPE_WR  = 2'b10;
  localparam logic [1:0] TYPE_RD  = 2'b11;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SETUP = 4'd1;
  localparam logic [3:0] S_CMD   = 4'd2;
  localparam logic [3:0] S_ADDR  = 4'd3;
  localparam logic [3:0] S_DUMMY = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_HOLD  = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
`ifdef SPI_FL_WIP_POLL_EN
  localparam logic [3:0] S_GAP   = 4'd8;
`endif

  logic [3:0]        state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_nxt;
  logic [TX_W-1:0]   tx_sr, tx_nxt;
  logic [DATA_W-1:0] rx_sr, rx_nxt;
  logic [1:0]        type_q, type_nxt;
  logic [NB_W-1:0]   nb_q, nb_nxt;
  logic [DUMMY_W-1:0] nd_q, nd_nxt;
  logic              ss_nxt, sclk_nxt, mosi_nxt, tready_nxt, vf_nxt;
  logic [DATA_W-1:0] dout_nxt;

  logic              tick, is_read, cur_live, nxt_live;
  logic [3:0]        phase_nxt, st_after;
  logic [CNT_W-1:0]  len_nxt;
  logic [NB_W-1:0]   nb_clamp, b_eff;
  logic [TX_W-1:0]   tx_shift;

`ifdef SPI_FL_WIP_POLL_EN
  logic poll_q, poll_nxt;
  assign is_read = (type_q == TYPE_RD) || poll_q;
`else
  assign is_read = (type_q == TYPE_RD);
`endif

  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign nb_clamp = (nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes;
  assign b_eff    = cmd_type[1] ? nb_clamp : '0;
  assign tx_shift = tx_sr << 1;
  assign st_after = (bit_cnt == CNT_W'(1)) ? phase_nxt : state;
  assign cur_live = (state == S_CMD) || (state == S_ADDR) || ((state == S_DATA) && !is_read);
  assign nxt_live = (st_after == S_CMD) || (st_after == S_ADDR) || ((st_after == S_DATA) && !is_read);

  // Phase that follows the current one once its last bit has shifted; empty phases are skipped.
  always_comb begin
    phase_nxt = S_HOLD;
    len_nxt   = '0;
    case (state)
      S_CMD: begin
`ifdef SPI_FL_WIP_POLL_EN
        if (poll_q) begin
          phase_nxt = S_DATA;
          len_nxt   = CNT_W'(8);
        end else
`endif
        if (type_q != TYPE_CMD) begin
          phase_nxt = S_ADDR;
          len_nxt   = CNT_W'(ADDR_W);
        end
      end
      S_ADDR: begin
        if ((type_q == TYPE_RD) && (nd_q != '0)) begin
          phase_nxt = S_DUMMY;
          len_nxt   = CNT_W'(nd_q);
        end else if (nb_q != '0) begin
          phase_nxt = S_DATA;
          len_nxt   = CNT_W'({nb_q, 3'b000});
        end
      end
      S_DUMMY: begin
        if (nb_q != '0) begin
          phase_nxt = S_DATA;
          len_nxt   = CNT_W'({nb_q, 3'b000});
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    tx_nxt     = tx_sr;
    rx_nxt     = rx_sr;
    type_nxt   = type_q;
    nb_nxt     = nb_q;
    nd_nxt     = nd_q;
    ss_nxt     = ss;
    sclk_nxt   = sclk;
    mosi_nxt   = mosi;
    tready_nxt = tready;
    vf_nxt     = 1'b0;
    dout_nxt   = data_out;
`ifdef SPI_FL_WIP_POLL_EN
    poll_nxt   = poll_q;
`endif
    case (state)
      S_IDLE: begin
        if (validflag && tready) begin
          state_nxt  = S_SETUP;
          div_nxt    = '0;
          type_nxt   = cmd_type;
          nb_nxt     = b_eff;
          nd_nxt     = (cmd_type == TYPE_RD) ? ndummy : '0;
          tx_nxt     = {command, address, data_in << {NB_W'(MAX_BYTES) - b_eff, 3'b000}};
          rx_nxt     = '0;
          ss_nxt     = 1'b0;
          tready_nxt = 1'b0;
          mosi_nxt   = command[7];
        end
      end
      S_SETUP: begin
        if (tick) begin
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          state_nxt = S_CMD;
          bit_nxt   = CNT_W'(8);
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (tick) begin
          div_nxt  = '0;
          sclk_nxt = ~sclk;
          if (!sclk) begin
            // Rising edge: capture read data.
            if ((state == S_DATA) && is_read) rx_nxt = {rx_sr[DATA_W-2:0], miso};
          end else begin
            // Falling edge: retire one bit and present the next.
            if (bit_cnt == CNT_W'(1)) begin
              state_nxt = phase_nxt;
              bit_nxt   = len_nxt;
            end else begin
              bit_nxt = bit_cnt - CNT_W'(1);
            end
            if (cur_live) tx_nxt = tx_shift;
            mosi_nxt = nxt_live ? tx_shift[TX_W-1] : 1'b0;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (tick) begin
          div_nxt   = '0;
          ss_nxt    = 1'b1;
          state_nxt = S_DONE;
`ifdef SPI_FL_WIP_POLL_EN
          if (poll_q ? rx_sr[0] : (type_q == TYPE_WR)) state_nxt = S_GAP;
`endif
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
`ifdef SPI_FL_WIP_POLL_EN
      S_GAP: begin
        if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
          div_nxt   = '0;
          ss_nxt    = 1'b0;
          state_nxt = S_SETUP;
          tx_nxt    = {8'h05, {(TX_W - 8){1'b0}}};
          rx_nxt    = '0;
          poll_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
`endif
      S_DONE: begin
        vf_nxt     = 1'b1;
        tready_nxt = 1'b1;
        state_nxt  = S_IDLE;
        if ((type_q == TYPE_RD) && (nb_q != '0)) dout_nxt = rx_sr;
`ifdef SPI_FL_WIP_POLL_EN
        poll_nxt   = 1'b0;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      type_q        <= TYPE_CMD;
      nb_q          <= '0;
      nd_q          <= '0;
      ss            <= 1'b1;
      sclk          <= 1'b0;
      mosi          <= 1'b0;
      tready        <= 1'b1;
      validflag_out <= 1'b0;
      data_out      <= '0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      bit_cnt       <= bit_nxt;
      tx_sr         <= tx_nxt;
      rx_sr         <= rx_nxt;
      type_q        <= type_nxt;
      nb_q          <= nb_nxt;
      nd_q          <= nd_nxt;
      ss            <= ss_nxt;
      sclk          <= sclk_nxt;
      mosi          <= mosi_nxt;
      tready        <= tready_nxt;
      validflag_out <= vf_nxt;
      data_out      <= dout_nxt;
    end
  end

`ifdef SPI_FL_WIP_POLL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) poll_q <= 1'b0;
    else        poll_q <= poll_nxt;
  end
`endif

endmodule

// File: tb/tb_spi_master_fl_param.sv
// Randomised bench for spi_master_fl_param against a bit-list flash model with cycle-timing checks.
module tb_spi_master_fl_param;

  localparam int CD     = 2;
  localparam int AW     = 24;
  localparam int MB     = 4;
  localparam int DW     = 4;
  localparam int BUDGET = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss, sclk, mosi, miso;
  logic [7:0]  command;
  logic [AW-1:0] address;
  logic [1:0]  cmd_type;
  logic [$clog2(MB):0] nbytes;
  logic [DW-1:0] ndummy;
  logic [8*MB-1:0] data_in, data_out;
  logic        validflag, tready, validflag_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_do;
  logic        cur_rd;
  int          cur_pre, cur_dbits;
  logic [31:0] cur_resp;

  always #5 clk = ~clk;

  spi_master_fl_param #(.CLK_DIV(CD), .ADDR_W(AW), .MAX_BYTES(MB), .DUMMY_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .command(command), .address(address), .cmd_type(cmd_type), .nbytes(nbytes),
    .ndummy(ndummy), .data_in(data_in), .data_out(data_out), .validflag(validflag),
    .tready(tready), .validflag_out(validflag_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash side: read data follows cmd/addr/dummy bits; anything else on miso is junk.
  function automatic logic miso_bit(input int k);
    if (cur_rd && k >= cur_pre && k < cur_pre + cur_dbits)
      return cur_resp[cur_dbits - 1 - (k - cur_pre)];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_txn(input logic [1:0] ct, input logic [7:0] cmd, input logic [23:0] addr,
                         input int nb, input int nd, input logic [31:0] din, input logic [31:0] resp,
                         input int vf_at, input int rst_at);
    int b, a, d, nbits, k;
    int rises, first_rise, last_fall, ss_rise, vf_cyc, vf_cnt, low_cnt;
    logic [127:0] exp_s, got_s;
    logic [31:0] exp_do, mask;
    logic p_sclk, p_ss, tr_at_vf, mo_at_vf;

    b     = ct[1] ? ((nb > MB) ? MB : nb) : 0;
    a     = (ct != 2'b00) ? AW : 0;
    d     = (ct == 2'b11) ? nd : 0;
    nbits = 8 + a + d + 8 * b;
    exp_s = '0;
    for (int i = 7; i >= 0; i--)     exp_s = {exp_s[126:0], cmd[i]};
    for (int i = a - 1; i >= 0; i--) exp_s = {exp_s[126:0], addr[i]};
    for (int i = 0; i < d; i++)      exp_s = {exp_s[126:0], 1'b0};
    for (int i = 8*b - 1; i >= 0; i--) exp_s = {exp_s[126:0], (ct == 2'b10) ? din[i] : 1'b0};
    mask   = (b == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * b)) - 32'd1);
    exp_do = (ct == 2'b11 && b > 0) ? (resp & mask) : model_do;

    cur_rd = (ct == 2'b11); cur_pre = 8 + a + d; cur_dbits = 8 * b; cur_resp = resp;

    k = 0;
    @(negedge clk);
    while (tready !== 1'b1 && k < BUDGET) begin @(negedge clk); k++; end
    check("tready_idle", 128'(tready), 128'(1));
    command = cmd; address = addr; cmd_type = ct; nbytes = 3'(nb); ndummy = 4'(nd);
    data_in = din; miso = miso_bit(0); validflag = 1'b1;
    @(posedge clk);

    p_sclk = 1'b0; p_ss = 1'b1; rises = 0; first_rise = -1; last_fall = -1; ss_rise = -1;
    vf_cyc = -1; vf_cnt = 0; got_s = '0; tr_at_vf = 1'b0; mo_at_vf = 1'b1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      validflag = (n == vf_at);
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_ss", 128'(ss), 128'(1));
        check("rst_sclk", 128'(sclk), 128'(0));
        check("rst_tready", 128'(tready), 128'(1));
        check("rst_vf", 128'(validflag_out), 128'(0));
        check("rst_dout", 128'(data_out), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_do = '0;
        vf_cnt = 0; low_cnt = 0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (validflag_out) vf_cnt++;
          if (!ss) low_cnt++;
        end
        check("rst_no_vf", 128'(vf_cnt), 128'(0));
        check("rst_ss_idle", 128'(low_cnt), 128'(0));
        return;
      end
      if (n == 1) begin
        check("ss_fall", 128'(ss), 128'(0));
        check("tready_busy", 128'(tready), 128'(0));
      end
      if (!p_sclk && sclk) begin
        if (first_rise < 0) first_rise = n;
        rises++;
        got_s = {got_s[126:0], mosi};
      end
      if (p_sclk && !sclk) begin
        last_fall = n;
        miso = miso_bit(rises);
      end
      if (!p_ss && ss) ss_rise = n;
      if (validflag_out) begin
        vf_cnt++;
        if (vf_cyc < 0) begin vf_cyc = n; tr_at_vf = tready; mo_at_vf = mosi; end
      end
      p_sclk = sclk; p_ss = ss;
      if (vf_cyc > 0 && n >= vf_cyc + 4) break;
    end
    validflag = 1'b0;

    check("rises", 128'(rises), 128'(nbits));
    check("mosi_stream", got_s, exp_s);
    check("first_rise", 128'(first_rise), 128'(1 + CD));
    check("last_fall", 128'(last_fall), 128'(1 + 2 * CD * nbits));
    check("ss_rise", 128'(ss_rise), 128'(1 + CD * (2 * nbits + 1)));
    check("vf_cycle", 128'(vf_cyc), 128'(2 + CD * (2 * nbits + 1)));
    check("vf_count", 128'(vf_cnt), 128'(1));
    check("tready_at_vf", 128'(tr_at_vf), 128'(1));
    check("mosi_idle", 128'(mo_at_vf), 128'(0));
    check("data_out", 128'(data_out), 128'(exp_do));
    model_do = exp_do;
  endtask

  initial begin
    rst_n = 1'b0; validflag = 1'b0; miso = 1'b0; command = '0; address = '0;
    cmd_type = '0; nbytes = '0; ndummy = '0; data_in = '0; model_do = '0;
    cur_rd = 1'b0; cur_pre = 0; cur_dbits = 0; cur_resp = '0;
    repeat (3) @(negedge clk);
    check("reset_ss", 128'(ss), 128'(1));
    check("reset_sclk", 128'(sclk), 128'(0));
    check("reset_mosi", 128'(mosi), 128'(0));
    check("reset_tready", 128'(tready), 128'(1));
    check("reset_vf", 128'(validflag_out), 128'(0));
    check("reset_dout", 128'(data_out), 128'(0));
    rst_n = 1'b1;

    run_txn(2'b11, 8'h03, 24'h555555, 1, 0, 32'h0, 32'h0000_00BD, 0, 0);
    run_txn(2'b10, 8'h02, 24'h001000, 2, 0, 32'h0000_A55A, 32'h0, 0, 0);
    run_txn(2'b00, 8'h06, 24'hABCDEF, 3, 5, 32'h1234_5678, 32'h0, 0, 0);
    run_txn(2'b11, 8'h0B, 24'h012345, 4, 8, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_txn(2'b11, 8'h03, 24'h00F0F0, 7, 0, 32'h0, 32'hC3A5_5A3C, 9, 0);
    run_txn(2'b10, 8'h02, 24'h7E7E7E, 7, 3, 32'h8142_24FF, 32'h0, 30, 0);
    run_txn(2'b01, 8'hD8, 24'h123456, 0, 0, 32'h0, 32'h0, 0, 1 + 2 * CD * 8 + 5);
    run_txn(2'b11, 8'h03, 24'h000010, 2, 2, 32'h0, 32'h0000_6E91, 0, 0);
    run_txn(2'b11, 8'h03, 24'h000020, 0, 4, 32'h0, 32'h0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      run_txn(2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), $urandom, $urandom, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_fl_param.md
Name: spi_master_fl_param

Overview:
- Parametrised SPI NOR-flash master: next generation of the single-byte flash master.
- Runs one transaction per request: command, optional address, optional dummy cycles, then 0..MAX_BYTES data bytes in either direction.
- Sits between the flash controller (valid/ready style request port) and the external flash pins. SPI mode 0, MSB first.

Parameters:
- CLK_DIV, 1, sclk half-period in clk cycles (>=1); sclk period = 2*CLK_DIV clk.
- ADDR_W, 24, address width in bits (24 or 32).
- MAX_BYTES, 4, maximum data bytes per transaction.
- DUMMY_W, 4, width of the dummy-cycle count input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ss  out  1  flash chip select, active low
- sclk  out  1  SPI clock, idles low
- mosi  out  1  master data out
- miso  in  1  master data in
- command  in  8  instruction byte
- address  in  ADDR_W  flash address
- cmd_type  in  2  00 cmd only, 01 cmd+addr, 10 write (cmd+addr+data out), 11 read (cmd+addr+dummy+data in)
- nbytes  in  $clog2(MAX_BYTES)+1  data byte count
- ndummy  in  DUMMY_W  dummy sclk cycles (read only)
- data_in  in  8*MAX_BYTES  write data, right-aligned
- data_out  out  8*MAX_BYTES  read data, right-aligned
- validflag  in  1  request strobe
- tready  out  1  ready for request
- validflag_out  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): ss=1, sclk=0, mosi=0, tready=1, validflag_out=0, data_out=0, FSM=IDLE. A transaction in flight is abandoned and no completion pulse is issued.
- Request capture:
  - Inputs are registered on the clk edge where validflag=1 and tready=1 (cycle 0). tready=0 from cycle 1.
  - validflag while tready=0 is ignored.
- Effective counts:
  - B = min(nbytes, MAX_BYTES) for types 10/11, else 0.
  - A = ADDR_W for types 01/10/11, else 0.
  - D = ndummy for type 11, else 0.
  - N = 8 + A + D + 8*B sclk cycles.
- FSM states: IDLE -> SETUP -> CMD -> ADDR -> DUMMY -> DATA -> HOLD -> DONE -> IDLE. Phases with zero length are skipped.
- Timing:
  - ss falls at cycle 1.
  - First sclk rise at cycle 1+CLK_DIV; every sclk half-period is CLK_DIV clk cycles.
  - Last sclk fall at cycle 1+2*CLK_DIV*N.
  - ss rises at 1+CLK_DIV*(2N+1).
  - validflag_out=1 for exactly one cycle, the cycle after ss rises. tready returns to 1 in the same cycle.
- mosi:
  - The first bit (command[7]) is valid when ss falls; later bits change on sclk falling edges. MSB-first order: command, address[A-1:0], then data_in bytes B-1 down to 0.
  - During DUMMY and read DATA, mosi=0. After HOLD, mosi=0.
- miso: sampled on sclk rising edges during read DATA and shifted in at the LSB. data_out = received 8*B bits right-aligned, upper bits zero.
- data_out: updates only in the DONE cycle of a read. Otherwise it holds its last value.
- Type 10/11 with nbytes=0 behaves as cmd+addr (type 11 still issues its D dummy cycles).

Optional Feature:
- Macro: SPI_FL_WIP_POLL_EN.
- With the macro, after a type-10 transaction (or type-00 with command 0x06/0xC7/0x20/0xD8 excluded: only type 10), the master:
  1. Deasserts ss for 2*CLK_DIV cycles.
  2. Issues 0x05 (read status) and reads one byte; repeats while bit0 (WIP)=1.
  3. Raises validflag_out only after a status byte with bit0=0 is read.
  - Status bytes do not update data_out.
- Without the macro: no polling states; timing exactly as above.

Test Plan:
- Read: cmd_type=11, command=0x03, address=0x555555, ndummy=0, nbytes=1, miso bits 1,0,1,1,1,1,0,1 -> mosi shows 0x03 then 0x555555; data_out=0x000000BD; validflag_out pulses at cycle 1+CLK_DIV*(2*40+1)+1; tready=1 with it.
- Write: cmd_type=10, command=0x02, address=0x001000, nbytes=2, data_in=0x0000A55A -> mosi bit stream 0x02,0x00,0x10,0x00,0xA5,0x5A; 48 sclk rises; data_out unchanged.
- Command only: cmd_type=00, command=0x06 -> exactly 8 sclk cycles, ss low only during them, one validflag_out pulse.
- Fast read with dummy: cmd_type=11, command=0x0B, ndummy=8, nbytes=4, miso stream 0xDEADBEEF after dummies -> data_out=0xDEADBEEF, N=72.
- Clamp/ignore: nbytes=7 with MAX_BYTES=4 -> 4 bytes transferred; validflag pulsed mid-transaction -> ignored, one completion only.
- Reset mid-ADDR: rst_n low for 1 cycle -> ss=1, sclk=0 immediately, no validflag_out, tready=1; a following request completes normally. With SPI_FL_WIP_POLL_EN: status 0x01,0x01,0x00 -> three 0x05 polls before validflag_out.
